// File: rtl/simon_game_ctrl.sv
// Simon memory-game controller: grows a random colour sequence one step per
// round, plays it back on the LEDs at tick pace, then checks the player's
// button presses against it, with a per-press timeout.
module simon_game_ctrl #(
  parameter int MAX_LEN   = 16,
  parameter int ON_TICKS  = 8,
  parameter int OFF_TICKS = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] btn,
  input  logic [1:0] rand_in,     // random colour index ("rand" is a reserved word)
  input  logic       tick,
  input  logic       rsg_done,
  output logic       rsg_start,
  output logic [3:0] led,
  output logic       IncCounter,
  output logic [4:0] score,
  output logic       game_over,
  output logic       win
);

  localparam int CNT_MAX_A = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int CNT_MAX   = (CNT_MAX_A > TIMEOUT) ? CNT_MAX_A : TIMEOUT;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(OFF_TICKS - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [4:0]       MAX_LEN_V = 5'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE, RSG, ADD, SHOW_ON, SHOW_OFF, WAIT_IN, LOSE, WIN
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       len_q, len_d;
  logic [3:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       score_q, score_d;

  logic [1:0]       seq_mem [16];
  logic             seq_we;
  logic [1:0]       seq_cur;
  logic [3:0]       exp_btn;
  logic             last_step;
  logic             rsg_start_c;
  logic             inc_c;

  assign seq_cur   = seq_mem[idx_q];
  assign exp_btn   = 4'b0001 << seq_cur;
  assign last_step = ({1'b0, idx_q} == (len_q - 5'd1));

  // Next-state and datapath update for the game FSM.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    score_d     = score_q;
    seq_we      = 1'b0;
    rsg_start_c = 1'b0;
    inc_c       = 1'b0;
    case (state_q)
      IDLE, LOSE, WIN: begin
        if (start) begin
          rsg_start_c = 1'b1;
          len_d       = 5'd0;
          score_d     = 5'd0;
          idx_d       = 4'd0;
          cnt_d       = '0;
          state_d     = RSG;
        end
      end
      RSG: begin
        if (rsg_done) state_d = ADD;
      end
      ADD: begin
        seq_we  = 1'b1;
        len_d   = len_q + 5'd1;
        idx_d   = 4'd0;
        cnt_d   = '0;
        state_d = SHOW_ON;
      end
      SHOW_ON: begin
        if (tick) begin
          if (cnt_q == ON_LAST) begin
            cnt_d   = '0;
            state_d = SHOW_OFF;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      SHOW_OFF: begin
        if (tick) begin
          if (cnt_q == OFF_LAST) begin
            cnt_d = '0;
            if (last_step) begin
              idx_d   = 4'd0;
              state_d = WAIT_IN;
            end else begin
              idx_d   = idx_q + 4'd1;
              state_d = SHOW_ON;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WAIT_IN: begin
        // A press takes precedence over a coincident tick, so a press on the
        // final tick still counts.
        if (btn != 4'b0000) begin
          if (btn != exp_btn) begin
            state_d = LOSE;
          end else if (!last_step) begin
            idx_d = idx_q + 4'd1;
            cnt_d = '0;
          end else begin
            inc_c   = 1'b1;
            score_d = len_q;
            state_d = (len_q == MAX_LEN_V) ? WIN : ADD;
          end
        end else if (tick) begin
          if (cnt_q == TO_LAST) begin
            cnt_d   = '0;
            state_d = LOSE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= 5'd0;
      idx_q   <= 4'd0;
      cnt_q   <= '0;
      score_q <= 5'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      score_q <= score_d;
    end
  end

  // Sequence storage; contents are don't-care until written by ADD.
  always_ff @(posedge clk) begin
    if (seq_we && !reset) seq_mem[len_q[3:0]] <= rand_in;
  end

  // Output decode; reset forces every output low in the same cycle.
  always_comb begin
    led        = 4'b0000;
    game_over  = 1'b0;
    win        = 1'b0;
    rsg_start  = 1'b0;
    IncCounter = 1'b0;
    score      = 5'd0;
    if (!reset) begin
      rsg_start  = rsg_start_c;
      IncCounter = inc_c;
      score      = score_q;
      case (state_q)
        SHOW_ON: led = exp_btn;
        WAIT_IN: led = btn;
        LOSE: begin
          led       = 4'b1111;
          game_over = 1'b1;
        end
        WIN: begin
          led = 4'b0101;
          win = 1'b1;
        end
        default: led = 4'b0000;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_game_ctrl.sv
// Directed bench for simon_game_ctrl: a default-parameter instance (A) and a
// MAX_LEN=2 instance (B) share all inputs.
module tb_simon_game_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic [1:0] rand_in = 2'd0;
  logic       tick = 1'b0;
  logic       rsg_done = 1'b0;

  logic       rsg_start_a, inc_a, game_over_a, win_a;
  logic [3:0] led_a;
  logic [4:0] score_a;
  logic       rsg_start_b, inc_b, game_over_b, win_b;
  logic [3:0] led_b;
  logic [4:0] score_b;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  simon_game_ctrl dut_a (
    .clk(clk), .reset(reset), .start(start), .btn(btn), .rand_in(rand_in),
    .tick(tick), .rsg_done(rsg_done), .rsg_start(rsg_start_a), .led(led_a),
    .IncCounter(inc_a), .score(score_a), .game_over(game_over_a), .win(win_a)
  );

  simon_game_ctrl #(.MAX_LEN(2)) dut_b (
    .clk(clk), .reset(reset), .start(start), .btn(btn), .rand_in(rand_in),
    .tick(tick), .rsg_done(rsg_done), .rsg_start(rsg_start_b), .led(led_b),
    .IncCounter(inc_b), .score(score_b), .game_over(game_over_b), .win(win_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic play(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
    end
  endtask

  initial begin
    // Reset state
    step(); step();
    chk("rst_led", led_a, 4'b0000);
    chk("rst_score", score_a, 5'd0);
    chk("rst_flags", {rsg_start_a, inc_a, game_over_a, win_a}, 4'b0000);
    reset = 1'b0;
    step();

    // Round 1: rand=2 -> led 0100 for 8 ticks, dark for 4
    start = 1'b1; #1;
    chk("start_pulse", rsg_start_a, 1'b1);
    step();
    start = 1'b0; #1;
    chk("start_pulse_end", rsg_start_a, 1'b0);
    chk("rsg_led", led_a, 4'b0000);
    rsg_done = 1'b1; rand_in = 2'd2;
    step();
    rsg_done = 1'b0;
    step();
    chk("r1_on", led_a, 4'b0100);
    play(7);
    chk("r1_on_7", led_a, 4'b0100);
    play(1);
    chk("r1_on_end", led_a, 4'b0000);
    play(3);
    btn = 4'b0100; #1;
    chk("off_btn_ignored", led_a, 4'b0000);
    chk("off_btn_no_inc", inc_a, 1'b0);
    step();
    btn = 4'b0000;
    play(1);

    // Correct press -> IncCounter, score 1; round 2 with rand=0
    rand_in = 2'd0;
    btn = 4'b0100; #1;
    chk("r1_echo", led_a, 4'b0100);
    chk("r1_inc", inc_a, 1'b1);
    step();
    btn = 4'b0000; #1;
    chk("r1_inc_end", inc_a, 1'b0);
    chk("r1_score", score_a, 5'd1);
    step();
    chk("r2_first", led_a, 4'b0100);
    play(8);
    chk("r2_gap", led_a, 4'b0000);
    play(4);
    chk("r2_second", led_a, 4'b0001);
    play(12);

    // Wrong press -> LOSE
    btn = 4'b1000; #1;
    chk("wrong_no_inc", inc_a, 1'b0);
    step();
    btn = 4'b0000;
    chk("lose_flag", game_over_a, 1'b1);
    chk("lose_led", led_a, 4'b1111);
    chk("lose_score", score_a, 5'd1);
    step();
    chk("lose_sticky", game_over_a, 1'b1);
    start = 1'b1; #1;
    chk("restart_pulse", rsg_start_a, 1'b1);
    step();
    start = 1'b0;
    chk("restart_score", score_a, 5'd0);
    chk("restart_go", game_over_a, 1'b0);

    // Timeout: seq {1,3}; press idx0 on the 63rd tick, then 64 more ticks
    rsg_done = 1'b1; rand_in = 2'd1;
    step();
    rsg_done = 1'b0;
    step();
    chk("t_r1_on", led_a, 4'b0010);
    play(12);
    rand_in = 2'd3;
    btn = 4'b0010;
    step();
    btn = 4'b0000;
    step();
    play(24);
    play(62);
    chk("t_62_alive", game_over_a, 1'b0);
    tick = 1'b1; btn = 4'b0010; #1;
    chk("t_63_no_inc", inc_a, 1'b0);
    step();
    tick = 1'b0; btn = 4'b0000;
    step();
    chk("t_63_press_alive", game_over_a, 1'b0);
    play(63);
    chk("t_63_more_alive", game_over_a, 1'b0);
    play(1);
    chk("t_64_lose", game_over_a, 1'b1);
    chk("t_64_led", led_a, 4'b1111);

    // Reset mid-playback, with start asserted alongside
    start = 1'b1;
    step();
    start = 1'b0;
    rsg_done = 1'b1; rand_in = 2'd2;
    step();
    rsg_done = 1'b0;
    step();
    play(3);
    chk("m_on", led_a, 4'b0100);
    reset = 1'b1; start = 1'b1; #1;
    chk("m_rst_no_pulse", rsg_start_a, 1'b0);
    step();
    reset = 1'b0; start = 1'b0; #1;
    chk("m_rst_outs", {led_a, score_a, inc_a, game_over_a, win_a, rsg_start_a}, 13'd0);
    start = 1'b1; #1;
    chk("m_idle_start", rsg_start_a, 1'b1);
    step();
    start = 1'b0;
    rsg_done = 1'b1; rand_in = 2'd1;
    step();
    rsg_done = 1'b0;
    step();
    play(8);
    start = 1'b1; #1;
    chk("m_off_start_ign", rsg_start_a, 1'b0);
    step();
    start = 1'b0;
    play(4);
    btn = 4'b0011; #1;
    chk("m_multi_echo", led_a, 4'b0011);
    step();
    btn = 4'b0000;
    chk("m_multi_lose", game_over_a, 1'b1);

    // Win with MAX_LEN=2 (instance B), rand=3 both rounds
    start = 1'b1;
    step();
    start = 1'b0;
    rsg_done = 1'b1; rand_in = 2'd3;
    step();
    rsg_done = 1'b0;
    step();
    chk("w_r1_on", led_b, 4'b1000);
    play(12);
    btn = 4'b1000; #1;
    chk("w_r1_inc", inc_b, 1'b1);
    step();
    btn = 4'b0000;
    step();
    play(24);
    btn = 4'b1000;
    step();
    btn = 4'b1000; #1;
    chk("w_r2_inc", inc_b, 1'b1);
    step();
    btn = 4'b0000; #1;
    chk("w_win", win_b, 1'b1);
    chk("w_led", led_b, 4'b0101);
    chk("w_score", score_b, 5'd2);
    chk("w_inc_end", inc_b, 1'b0);
    chk("w_a_no_win", win_a, 1'b0);
    chk("w_a_score", score_a, 5'd2);
    step();
    chk("w_sticky", win_b, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/simon_game_ctrl.md
SIMON_GAME_CTRL -- requirements
Module: simon_game_ctrl

Interface
REQ-001 Parameter MAX_LEN, default 16, final sequence length that wins the game; legal range 1..16.
REQ-002 Parameter ON_TICKS, default 8, number of tick pulses an LED stays lit during playback.
REQ-003 Parameter OFF_TICKS, default 4, number of tick pulses of dark gap after each playback LED.
REQ-004 Parameter TIMEOUT, default 64, number of tick pulses allowed between player presses.
REQ-005 clk  in  1  system clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  single-cycle request to begin a new game.
REQ-008 btn  in  4  debounced single-cycle button pulses, one bit per colour.
REQ-009 rand  in  2  random colour index, sampled only in ADD.
REQ-010 tick  in  1  single-cycle timebase enable; all playback and timeout counters advance only on tick.
REQ-011 rsg_done  in  1  single-cycle pulse from the ready/set/go display when its countdown ends.
REQ-012 rsg_start  out  1  single-cycle pulse that launches the ready/set/go countdown.
REQ-013 led  out  4  colour LED drive.
REQ-014 IncCounter  out  1  single-cycle pulse per completed round, for the score display counter.
REQ-015 score  out  5  number of rounds completed in the current game.
REQ-016 game_over  out  1  high while in LOSE.
REQ-017 win  out  1  high while in WIN.

Function
REQ-018 States: IDLE, RSG, ADD, SHOW_ON, SHOW_OFF, WAIT_IN, LOSE, WIN; storage is a 16x2-bit sequence array, 5-bit length, 4-bit idx, and a tick counter wide enough for max(ON_TICKS, OFF_TICKS, TIMEOUT).
REQ-019 IDLE/LOSE/WIN + start: rsg_start=1 for exactly that cycle; length, score, idx cleared; next RSG; start in any other state is ignored.
REQ-020 RSG: led=0; hold until rsg_done, then ADD.
REQ-021 ADD (one cycle): seq[length]<=rand; length<=length+1; idx<=0; tick counter cleared; next SHOW_ON.
REQ-022 SHOW_ON: led=onehot(seq[idx]) (0->0001, 1->0010, 2->0100, 3->1000); after ON_TICKS ticks, counter cleared, next SHOW_OFF.
REQ-023 SHOW_OFF: led=0; after OFF_TICKS ticks: if idx==length-1, then idx<=0 and next WAIT_IN; otherwise idx<=idx+1 and next SHOW_ON.
REQ-024 btn pulses during RSG, ADD, SHOW_ON and SHOW_OFF are ignored.
REQ-025 WAIT_IN: led=btn (combinational echo); any nonzero btn is one press.
REQ-026 Wrong press (btn not one-hot, or btn != onehot(seq[idx])): next LOSE.
REQ-027 Correct press with idx<length-1: idx+1; tick counter cleared.
REQ-028 Correct press with idx==length-1: IncCounter=1 that cycle; score<=length.
REQ-029 After REQ-028, next is WIN if length==MAX_LEN, else ADD.
REQ-030 WAIT_IN timeout: when the counter reaches TIMEOUT ticks with no press, next LOSE.
REQ-031 Same-cycle tick and btn: the press is evaluated and the timeout does not fire that cycle.
REQ-032 LOSE: led=1111, game_over=1, score held.
REQ-033 WIN: led=0101, win=1, score=MAX_LEN.
REQ-034 LOSE/WIN are left only by start (REQ-019).
REQ-035 rsg_start and IncCounter are never high for two consecutive cycles.

Reset
REQ-036 reset high at any edge, including mid-playback or mid-input: state IDLE; led, score, length, idx, counters, rsg_start, IncCounter, game_over, win all 0.
REQ-037 Sequence array contents need no reset.
REQ-038 reset has priority over start and all other inputs in the same cycle.

Verification
REQ-039 Scenario: reset, then start, then rsg_done, with rand=2 -> rsg_start pulses once; led=0100 for 8 ticks then 0000 for 4 ticks; state WAIT_IN.
REQ-040 Scenario: round 1 seq {2}, press btn=0100 -> IncCounter one pulse, score=1; with rand=0 round 2 plays 0100 then 0001.
REQ-041 Scenario: round 2 seq {2,0}, press btn=1000 first -> game_over=1, led=1111, score=1; then start -> rsg_start pulse, score=0.
REQ-042 Scenario: MAX_LEN=2, rand=3 in both rounds, correct presses both rounds -> second IncCounter, then win=1, led=0101, score=2.
REQ-043 Scenario: WAIT_IN with no press for 64 ticks -> LOSE at the 64th tick; a correct press on tick 63 clears the counter and no LOSE occurs.
REQ-044 Scenario: reset asserted during SHOW_ON, btn=0011 during WAIT_IN, and start during SHOW_OFF -> reset yields IDLE with all outputs 0; 0011 gives LOSE; start is ignored.
